// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. When a start request is accepted it latches two WIDTH-bit
// operands and a carry-in. It then adds them one bit per clock, LSB first,
// through a single full-adder cell and a carry flop. The result is written to
// sum/cout on the edge that processes the last bit, and done pulses for
// exactly one cycle.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN. When this macro is defined,
// the ovf port is added. It reports signed two's-complement overflow of the
// result.
//
// Parameters
//   WIDTH  operand / sum width in bits (1..64)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE or DONE
//   a, b   in   operands, sampled on the accepted start edge
//   cin    in   carry-in, sampled on the accepted start edge
//   busy   out  high while the addition is running
//   done   out  one-cycle pulse, result valid from this cycle on
//   sum    out  registered result, held until the next result
//   cout   out  registered carry-out of bit WIDTH-1
//   ovf    out  signed overflow (only with SERIAL_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry-out of a full adder: majority of the three inputs.
    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic              load_s;
    logic              step_s;
    logic              finish_s;

    logic [WIDTH-1:0]  a_sh_r;
    logic [WIDTH-1:0]  b_sh_r;
    logic [WIDTH-1:0]  work_r;
    logic [WIDTH-1:0]  work_nx_s;
    logic              carry_r;
    logic              carry_nx_s;
    logic              sum_bit_s;
    logic [CW-1:0]     cnt_r;

    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;

`ifdef SERIAL_ADDER_OVF_EN
    logic              a_msb_r;
    logic              b_msb_r;
    logic              ovf_r;
    logic              ovf_nx_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                // start is ignored here. It is not queued.
                step_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    finish_s   = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Full-adder cell and work-register shift for the current bit.
    always_comb begin
        sum_bit_s  = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
        carry_nx_s = majority(a_sh_r[0], b_sh_r[0], carry_r);
        // New bit enters at the MSB, so after WIDTH steps bit 0 sits at LSB.
        work_nx_s  = (work_r >> 1) | (WIDTH'(sum_bit_s) << (WIDTH - 1));
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: same-sign operands whose result sign differs.
    always_comb begin
        ovf_nx_s = (a_msb_r == b_msb_r) && (work_nx_s[WIDTH-1] != a_msb_r);
    end
`endif

    // Operand shift registers, carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            work_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            work_r  <= '0;
            carry_r <= cin;
            cnt_r   <= '0;
        end else if (step_s) begin
            a_sh_r  <= a_sh_r >> 1;
            b_sh_r  <= b_sh_r >> 1;
            work_r  <= work_nx_s;
            carry_r <= carry_nx_s;
            cnt_r   <= cnt_r + CW'(1);
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            work_r  <= work_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Result registers. They change only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (finish_s) begin
            sum_r  <= work_nx_s;
            cout_r <= carry_nx_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Operand sign bits kept for the overflow decision, and the ovf flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (load_s) begin
                a_msb_r <= a[WIDTH-1];
                b_msb_r <= b[WIDTH-1];
            end else begin
                a_msb_r <= a_msb_r;
                b_msb_r <= b_msb_r;
            end
            if (finish_s) begin
                ovf_r <= ovf_nx_s;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign ovf = ovf_r;
`endif

    // Registered status flags, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == RUN);
            done_r <= (state_nx_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed, self-checking bench for serial_adder. It instantiates three
// copies of the design with WIDTH=8, WIDTH=1 and WIDTH=16, all on one clock.
// Every expected value below is computed by hand from the arithmetic
// {cout,sum} = a + b + cin.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
`endif

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf1;
`endif

    // WIDTH=16 instance
    logic        start16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        cin16 = 1'b0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf16;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout1), .ovf(ovf1)
`else
        .cout(cout1)
`endif
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16),
`ifdef SERIAL_ADDER_OVF_EN
        .cout(cout16), .ovf(ovf16)
`else
        .cout(cout16)
`endif
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 add from a ready state. Then check the busy length,
    // the start-to-done latency and the result.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec,
                        input logic eo);
        int cyc;
        int busy_cnt;
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        tick();
        start8 = 1'b0;
        check({tag, "_busy"}, busy8, 1'b1);
        busy_cnt = 1;
        cyc = 0;
        while (!done8 && cyc < 30) begin
            tick();
            cyc++;
            if (busy8) busy_cnt++;
        end
        check({tag, "_lat"}, cyc, 8);
        check({tag, "_busycnt"}, busy_cnt, 8);
        check({tag, "_sum"}, sum8, es);
        check({tag, "_cout"}, cout8, ec);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, ovf8, eo);
`else
        if (eo) begin end
`endif
    endtask

    initial begin
        int cyc;
        int pulses;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_sum", sum8, 8'h00);
        check("rst_cout", cout8, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf8, 1'b0);
`endif
        tick();

        // ---------------- 0F + 01 -> 10, then hold ----------------
        run8("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        tick();
        check("t1_done_pulse", done8, 1'b0);
        check("t1_idle_busy", busy8, 1'b0);
        tick();
        check("t1_hold_sum", sum8, 8'h10);

        // ---------------- FF + 01 -> 00 c1, then back-to-back FF+FF+1 ----------------
        run8("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        // still in the DONE cycle: re-request immediately
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("t2b_busy", busy8, 1'b1);
        check("t2b_sum_stable", sum8, 8'h00);
        cyc = 1;
        while (!done8 && cyc < 30) begin
            tick();
            cyc++;
        end
        check("t2b_lat", cyc, 9);
        check("t2b_sum", sum8, 8'hFF);
        check("t2b_cout", cout8, 1'b1);
        tick();
        tick();

        // ---------------- start during RUN is ignored ----------------
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        cyc = 3;
        while (!done8 && cyc < 30) begin
            tick();
            cyc++;
        end
        check("t3_lat", cyc, 8);
        check("t3_sum", sum8, 8'h02);
        check("t3_cout", cout8, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) pulses++;
        end
        check("t3_no_second_done", pulses, 0);

        // ---------------- reset on the 4th RUN cycle ----------------
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        check("t4_busy_before", busy8, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", busy8, 1'b0);
        check("t4_done", done8, 1'b0);
        check("t4_sum", sum8, 8'h00);
        check("t4_cout", cout8, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8) pulses++;
        end
        check("t4_no_done", pulses, 0);

        // rst and start together: reset wins
        rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        tick();
        rst = 1'b0; start8 = 1'b0;
        check("t5_busy", busy8, 1'b0);
        tick();
        check("t5_busy_after", busy8, 1'b0);

        // ---------------- WIDTH=1: 1+1+1 -> sum 1 cout 1 ----------------
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", busy1, 1'b1);
        tick();
        check("w1_done", done1, 1'b1);
        check("w1_sum", sum1, 1'b1);
        check("w1_cout", cout1, 1'b1);
        tick();
        check("w1_done_gone", done1, 1'b0);

        // ---------------- WIDTH=16: FFFF + 0001 -> 0000 c1 ----------------
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
        tick();
        start16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("w16_lat", cyc, 16);
        check("w16_sum", sum16, 16'h0000);
        check("w16_cout", cout16, 1'b1);
        tick();

`ifdef SERIAL_ADDER_OVF_EN
        // ---------------- signed overflow ----------------
        run8("ov1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        tick();
        run8("ov2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        run8("ov3", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, 1'b0);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
